vga_stream_timing: RTL and testbench

Parametrised successor to the fixed 800x480 VGA controller. Generates HS/VS/active-video timing from fully generic porch/pulse/polarity parameters. Sources pixels from a show-ahead FIFO in the pixel domain, or from an internal test pattern. Detects FIFO underflow and resynchronises at the next frame boundary, requesting an upstream flush. Sits between the pixel-domain side of the async frame FIFO and the video output interface.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_timing_gen.sv | 95 +++++++++
 rtl/vga_stream_timing.sv | 120 ++++++++++++
 tb/tb_vga_stream_timing.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types, colour-bar table and bar index helper for the VGA stream timing block
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_GRID   = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_BLACK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  // floor(x*8/hdisp) without a divider: count the bar thresholds already crossed.
  function automatic logic [2:0] bar_index(input int x, input int hdisp);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x * 8 >= k * hdisp) idx = idx + 3'd1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - h/v counters and registered sync, data-enable and pixel coordinate outputs
module vga_timing_gen #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int XW     = $clog2(HDISP),
  parameter int YW     = $clog2(VDISP)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          hs_o,
  output logic          vs_o,
  output logic          video_blank_o,
  output logic [XW-1:0] pixel_x_o,
  output logic [YW-1:0] pixel_y_o,
  output logic          frame_start_o,
  output logic          frame_boundary_o
);

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_PS   = HW'(HFP);
  localparam logic [HW-1:0] H_PE   = HW'(HFP + HPULSE - 1);
  localparam logic [HW-1:0] H_AS   = HW'(HFP + HPULSE + HBP);
  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_PS   = VW'(VFP);
  localparam logic [VW-1:0] V_PE   = VW'(VFP + VPULSE - 1);
  localparam logic [VW-1:0] V_AS   = VW'(VFP + VPULSE + VBP);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          hs_q, hs_d, vs_q, vs_d, vb_q, vb_d, fs_q, fs_d;
  logic [XW-1:0] px_q, px_d;
  logic [YW-1:0] py_q, py_d;
  logic          h_act, v_act;

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
    h_act = (h_cnt_q >= H_AS);
    v_act = (v_cnt_q >= V_AS);
    hs_d  = (h_cnt_q >= H_PS && h_cnt_q <= H_PE) ? HS_POL : ~HS_POL;
    vs_d  = (v_cnt_q >= V_PS && v_cnt_q <= V_PE) ? VS_POL : ~VS_POL;
    vb_d  = h_act && v_act;
    fs_d  = (h_cnt_q == H_AS) && (v_cnt_q == V_AS);
    px_d  = vb_d ? XW'(h_cnt_q - H_AS) : '0;
    py_d  = vb_d ? YW'(v_cnt_q - V_AS) : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      vb_q    <= 1'b0;
      fs_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      vb_q    <= vb_d;
      fs_q    <= fs_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  assign hs_o             = hs_q;
  assign vs_o             = vs_q;
  assign video_blank_o    = vb_q;
  assign frame_start_o    = fs_q;
  assign pixel_x_o        = px_q;
  assign pixel_y_o        = py_q;
  assign frame_boundary_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_stream_timing.sv
// rtl/vga_stream_timing.sv - VGA timing with FIFO stream sourcing, test patterns and underflow resync
module vga_stream_timing
  import vga_pkg::*;
#(
  parameter int HDISP     = 800,
  parameter int VDISP     = 480,
  parameter int HFP       = 40,
  parameter int HPULSE    = 48,
  parameter int HBP       = 40,
  parameter int VFP       = 13,
  parameter int VPULSE    = 3,
  parameter int VBP       = 29,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int GRID_LOG2 = 4,
  parameter int UCNT_W    = 8
) (
  input  logic                       pixel_clk,
  input  logic                       pixel_rst,
  input  logic [1:0]                 mode,
  input  logic [31:0]                fifo_rdata,
  input  logic                       fifo_rempty,
  input  logic                       fifo_ready,
  output logic                       fifo_read,
  output logic                       resync_req,
  output logic                       hs,
  output logic                       vs,
  output logic                       video_blank,
  output logic [23:0]                rgb,
  output logic [$clog2(HDISP)-1:0]   pixel_x,
  output logic [$clog2(VDISP)-1:0]   pixel_y,
  output logic                       frame_start,
  output logic                       underflow,
  output logic [UCNT_W-1:0]          underflow_cnt
);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic                underflow_q, underflow_d;
  logic [UCNT_W-1:0]   ucnt_q, ucnt_d;
  logic                frame_boundary;
  logic                uf_event;
  logic                unused_rdata;

  vga_timing_gen #(
    .HDISP  (HDISP),
    .VDISP  (VDISP),
    .HFP    (HFP),
    .HPULSE (HPULSE),
    .HBP    (HBP),
    .VFP    (VFP),
    .VPULSE (VPULSE),
    .VBP    (VBP),
    .HS_POL (HS_POL),
    .VS_POL (VS_POL)
  ) u_timing (
    .clk_i            (pixel_clk),
    .rst_i            (pixel_rst),
    .hs_o             (hs),
    .vs_o             (vs),
    .video_blank_o    (video_blank),
    .pixel_x_o        (pixel_x),
    .pixel_y_o        (pixel_y),
    .frame_start_o    (frame_start),
    .frame_boundary_o (frame_boundary)
  );

  assign fifo_read    = video_blank && (state_q == ST_STREAM) && (mode_q == MODE_STREAM);
  assign unused_rdata = ^fifo_rdata[31:24];

  // The FSM decides against the mode of the frame about to start, so a boundary
  // that switches away from streaming never enters STREAM for a frame.
  always_comb begin
    mode_d     = frame_boundary ? mode_e'(mode) : mode_q;
    state_d    = state_q;
    uf_event   = (state_q == ST_STREAM) && fifo_read && fifo_rempty;
    resync_req = (state_q == ST_FAULT) && frame_boundary;
    case (state_q)
      ST_WAIT:   if (frame_boundary && fifo_ready) state_d = ST_STREAM;
      ST_STREAM: if (uf_event) state_d = ST_FAULT;
      ST_FAULT:  if (frame_boundary) state_d = ST_WAIT;
      default:   state_d = ST_WAIT;
    endcase
    if (mode_d != MODE_STREAM) state_d = ST_WAIT;
    underflow_d = underflow_q | uf_event;
    ucnt_d      = ucnt_q;
    if (uf_event && ucnt_q != '1) ucnt_d = ucnt_q + UCNT_W'(1);
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state_q     <= ST_WAIT;
      mode_q      <= MODE_STREAM;
      underflow_q <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      underflow_q <= underflow_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign underflow     = underflow_q;
  assign underflow_cnt = ucnt_q;

  // The head word is meaningless while empty, so an underflowing read shows black.
  always_comb begin
    rgb = '0;
    if (video_blank) begin
      case (mode_q)
        MODE_STREAM: if (fifo_read && !fifo_rempty) rgb = fifo_rdata[23:0];
        MODE_GRID:   if ((&pixel_x[GRID_LOG2-1:0]) || (&pixel_y[GRID_LOG2-1:0])) rgb = 24'hFFFFFF;
        MODE_BARS:   rgb = BAR_RGB[bar_index(int'(pixel_x), HDISP)];
        default:     rgb = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_stream_timing.sv
// tb/tb_vga_stream_timing.sv - directed self-checking bench for vga_stream_timing on a 14x7 timing
module tb_vga_stream_timing;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        fifo_ready = 1'b1;
  int          fifo_avail = 32;
  int          pop_cnt = 0;
  logic [31:0] fifo_rdata;
  logic        fifo_rempty;

  logic        fifo_read, resync_req, hs, vs, video_blank, frame_start, underflow;
  logic [23:0] rgb;
  logic [2:0]  pixel_x;
  logic [1:0]  pixel_y;
  logic [7:0]  underflow_cnt;

  logic        fifo_read2, resync_req2, hs2, vs2, video_blank2, frame_start2, underflow2;
  logic [23:0] rgb2;
  logic [2:0]  pixel_x2;
  logic [1:0]  pixel_y2;
  logic [7:0]  underflow_cnt2;

  int checks = 0;
  int errors = 0;

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  assign fifo_rdata  = {8'hA5, pop_cnt[23:0]};
  assign fifo_rempty = (pop_cnt >= fifo_avail);

  always #5 pixel_clk = ~pixel_clk;

  // Show-ahead FIFO model: head word is its own pop index; flushed by resync or reset.
  always @(posedge pixel_clk) begin
    if (pixel_rst || resync_req) pop_cnt <= 0;
    else if (fifo_read && !fifo_rempty) pop_cnt <= pop_cnt + 1;
  end

  vga_stream_timing #(
    .HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2),
    .VFP(1), .VPULSE(1), .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0),
    .GRID_LOG2(2), .UCNT_W(8)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .mode(mode),
    .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_ready(fifo_ready),
    .fifo_read(fifo_read), .resync_req(resync_req), .hs(hs), .vs(vs),
    .video_blank(video_blank), .rgb(rgb), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  vga_stream_timing #(
    .HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2),
    .VFP(1), .VPULSE(1), .VBP(1), .HS_POL(1'b1), .VS_POL(1'b1),
    .GRID_LOG2(2), .UCNT_W(8)
  ) dut_pol (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .mode(mode),
    .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_ready(fifo_ready),
    .fifo_read(fifo_read2), .resync_req(resync_req2), .hs(hs2), .vs(vs2),
    .video_blank(video_blank2), .rgb(rgb2), .pixel_x(pixel_x2), .pixel_y(pixel_y2),
    .frame_start(frame_start2), .underflow(underflow2), .underflow_cnt(underflow_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, ".hs"},  32'(hs), 32'd1);
    chk({t, ".vs"},  32'(vs), 32'd1);
    chk({t, ".vb"},  32'(video_blank), 32'd0);
    chk({t, ".rgb"}, 32'(rgb), 32'd0);
    chk({t, ".px"},  32'(pixel_x), 32'd0);
    chk({t, ".py"},  32'(pixel_y), 32'd0);
    chk({t, ".rd"},  32'(fifo_read), 32'd0);
    chk({t, ".rs"},  32'(resync_req), 32'd0);
    chk({t, ".fs"},  32'(frame_start), 32'd0);
    chk({t, ".uf"},  32'(underflow), 32'd0);
    chk({t, ".ucnt"}, 32'(underflow_cnt), 32'd0);
    chk({t, ".hs_pol"}, 32'(hs2), 32'd0);
    chk({t, ".vs_pol"}, 32'(vs2), 32'd0);
  endtask

  // md: 0 stream, 1 grid, 2 bars, 3 no output. Sample j shows the outputs of counter j of the frame.
  task automatic run_frame(input string nm, input int md, input int nrd, input int ndat,
                           input int base, input bit rs, input int ev_j,
                           input logic [1:0] ev_mode, input logic ev_ready, input int jmax);
    int h, v, n, rd_seen;
    bit act, rd_exp;
    logic [23:0] rgb_exp;
    rd_seen = 0;
    for (int j = 0; j < jmax; j++) begin
      @(negedge pixel_clk);
      h = j % 14;
      v = j / 14;
      act = (h >= 6) && (v >= 3);
      n = act ? (v - 3) * 8 + (h - 6) : 0;
      rd_exp = (md == 0) && act && (n < nrd);
      rgb_exp = 24'h0;
      if (act) begin
        case (md)
          0: if (n < ndat) rgb_exp = 24'(base + n);
          1: if ((h - 6) % 4 == 3 || (v - 3) % 4 == 3) rgb_exp = 24'hFFFFFF;
          2: rgb_exp = bar_tab[h - 6];
          default: rgb_exp = 24'h0;
        endcase
      end
      chk($sformatf("%s.hs.j%0d", nm, j),  32'(hs), 32'((h == 2 || h == 3) ? 0 : 1));
      chk($sformatf("%s.vs.j%0d", nm, j),  32'(vs), 32'((v == 1) ? 0 : 1));
      chk($sformatf("%s.hs_pol.j%0d", nm, j), 32'(hs2), 32'((h == 2 || h == 3) ? 1 : 0));
      chk($sformatf("%s.vs_pol.j%0d", nm, j), 32'(vs2), 32'((v == 1) ? 1 : 0));
      chk($sformatf("%s.vb.j%0d", nm, j),  32'(video_blank), 32'(act));
      chk($sformatf("%s.px.j%0d", nm, j),  32'(pixel_x), 32'(act ? h - 6 : 0));
      chk($sformatf("%s.py.j%0d", nm, j),  32'(pixel_y), 32'(act ? v - 3 : 0));
      chk($sformatf("%s.fs.j%0d", nm, j),  32'(frame_start), 32'(h == 6 && v == 3));
      chk($sformatf("%s.rd.j%0d", nm, j),  32'(fifo_read), 32'(rd_exp));
      chk($sformatf("%s.rgb.j%0d", nm, j), 32'(rgb), 32'(rgb_exp));
      chk($sformatf("%s.rs.j%0d", nm, j),  32'(resync_req), 32'(rs && j == 97));
      if (fifo_read) rd_seen++;
      if (j == ev_j) begin
        mode = ev_mode;
        fifo_ready = ev_ready;
      end
    end
    if (jmax == 98) chk({nm, ".pops"}, 32'(rd_seen), 32'(nrd));
  endtask

  initial begin
    pixel_rst = 1'b1;
    mode = 2'd0;
    fifo_ready = 1'b1;
    fifo_avail = 32;
    repeat (3) @(negedge pixel_clk);
    chk_reset("rst0");
    pixel_rst = 1'b0;

    run_frame("f0_stream", 0, 32, 32, 0, 1'b0, -1, 2'd0, 1'b1, 98);
    chk("f0.uf", 32'(underflow), 32'd0);
    chk("f0.ucnt", 32'(underflow_cnt), 32'd0);

    fifo_avail = 42;
    run_frame("f1_underflow", 0, 11, 10, 32, 1'b1, -1, 2'd0, 1'b1, 98);
    chk("f1.uf", 32'(underflow), 32'd1);
    chk("f1.ucnt", 32'(underflow_cnt), 32'd1);

    fifo_avail = 32;
    run_frame("f2_wait", 3, 0, 0, 0, 1'b0, -1, 2'd0, 1'b1, 98);
    run_frame("f3_stream", 0, 32, 32, 0, 1'b0, 20, 2'd1, 1'b1, 98);
    run_frame("f4_grid", 1, 0, 0, 0, 1'b0, 20, 2'd2, 1'b1, 98);
    fifo_avail = 64;
    run_frame("f5_bars", 2, 0, 0, 0, 1'b0, 20, 2'd0, 1'b1, 98);
    chk("f5.ucnt", 32'(underflow_cnt), 32'd1);
    run_frame("f6_stream", 0, 32, 32, 32, 1'b0, -1, 2'd0, 1'b1, 51);

    #2;
    pixel_rst = 1'b1;
    fifo_ready = 1'b0;
    fifo_avail = 32;
    #1;
    chk_reset("rst_mid");
    repeat (2) @(negedge pixel_clk);
    pixel_rst = 1'b0;

    run_frame("g0_noready", 3, 0, 0, 0, 1'b0, 30, 2'd0, 1'b1, 98);
    run_frame("g1_stream", 0, 32, 32, 0, 1'b0, -1, 2'd0, 1'b1, 98);
    chk("g1.uf", 32'(underflow), 32'd0);
    chk("g1.ucnt", 32'(underflow_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
